mem_stage: RTL and testbench

- MEM pipeline stage. Consumes the EX/MEM latch outputs and drives an external 16-bit asynchronous SRAM (data memory).
- Produces write-back data and control for the MEM/WB latch.
- Loads and stores run as multi-cycle FSM sequences. A stall request holds the EX/MEM latch and all earlier stages until the access completes.
- Non-memory instructions pass through with zero latency.

---
 rtl/mem_stage.sv | 173 +++++++++++++++++
 tb/tb_mem_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   MEM pipeline stage. Takes the EX/MEM latch outputs, runs loads and stores
//   against an external asynchronous 16-bit SRAM, and produces write-back data
//   and control for the MEM/WB latch. Non-memory instructions pass straight
//   through in the same cycle. Memory instructions take three cycles in the
//   stage and raise stallreq_o for the first two of them.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   memAddr_i       word address of the access
//   rMem_i, wMem_i  load / store request (load wins if both are set)
//   wData_i         ALU result, or the store data for a store
//   wReg_i          register write enable
//   wRegAddr_i      destination register
//   wData_o         write-back data to MEM/WB
//   wReg_o          write-back enable to MEM/WB
//   wRegAddr_o      write-back destination to MEM/WB
//   stallreq_o      freezes EX/MEM and every earlier stage
//   ram_addr_o      SRAM address (pipeline address zero-extended)
//   ram_data_o      SRAM write data
//   ram_data_i      SRAM read data
//   ram_data_oe_o   top level drives the bidirectional bus with ram_data_o
//   ram_en_n_o      SRAM chip enable, active-low
//   ram_oe_n_o      SRAM output enable, active-low
//   ram_we_n_o      SRAM write enable, active-low
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int DATA_W  = 16,
    parameter int MADDR_W = 16,
    parameter int RAM_AW  = 18,
    parameter int RADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MADDR_W-1:0] memAddr_i,
    input  logic               rMem_i,
    input  logic               wMem_i,
    input  logic [DATA_W-1:0]  wData_i,
    input  logic               wReg_i,
    input  logic [RADDR_W-1:0] wRegAddr_i,
    output logic [DATA_W-1:0]  wData_o,
    output logic               wReg_o,
    output logic [RADDR_W-1:0] wRegAddr_o,
    output logic               stallreq_o,
    output logic [RAM_AW-1:0]  ram_addr_o,
    output logic [DATA_W-1:0]  ram_data_o,
    input  logic [DATA_W-1:0]  ram_data_i,
    output logic               ram_data_oe_o,
    output logic               ram_en_n_o,
    output logic               ram_oe_n_o,
    output logic               ram_we_n_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_r;
    logic                is_load_r;   // remembers load vs store for DONE
    logic [DATA_W-1:0]   rdata_r;     // word captured from the SRAM in RD
    logic [RAM_AW-1:0]   ram_addr_s;

    // Pipeline word address zero-extended onto the wider SRAM address bus.
    assign ram_addr_s = {{(RAM_AW-MADDR_W){1'b0}}, memAddr_i};

    // Access sequencer: IDLE -> RD|WR -> DONE -> IDLE, plus read-data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            is_load_r <= 1'b0;
            rdata_r   <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rMem_i) begin
                        state_r   <= ST_RD;
                        is_load_r <= 1'b1;
                    end else if (wMem_i) begin
                        state_r   <= ST_WR;
                        is_load_r <= 1'b0;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    rdata_r <= ram_data_i;
                    state_r <= ST_DONE;
                end
                ST_WR:   state_r <= ST_DONE;
                ST_DONE: state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Output decode from state and the (stall-held) EX/MEM inputs. Reset
    // overrides everything so the SRAM is released the instant rst rises.
    always_comb begin
        wData_o       = wData_i;
        wReg_o        = wReg_i;
        wRegAddr_o    = wRegAddr_i;
        stallreq_o    = 1'b0;
        ram_addr_o    = {RAM_AW{1'b0}};
        ram_data_o    = {DATA_W{1'b0}};
        ram_data_oe_o = 1'b0;
        ram_en_n_o    = 1'b1;
        ram_oe_n_o    = 1'b1;
        ram_we_n_o    = 1'b1;
        if (rst) begin
            wData_o    = {DATA_W{1'b0}};
            wReg_o     = 1'b0;
            wRegAddr_o = {RADDR_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rMem_i) begin
                        stallreq_o = 1'b1;
                        wReg_o     = 1'b0;
                        ram_addr_o = ram_addr_s;
                        ram_en_n_o = 1'b0;
                        ram_oe_n_o = 1'b0;
                    end else if (wMem_i) begin
                        // Address/data setup cycle; WE stays high.
                        stallreq_o    = 1'b1;
                        wReg_o        = 1'b0;
                        ram_addr_o    = ram_addr_s;
                        ram_data_o    = wData_i;
                        ram_data_oe_o = 1'b1;
                        ram_en_n_o    = 1'b0;
                    end else begin
                        stallreq_o = 1'b0;
                    end
                end
                ST_RD: begin
                    stallreq_o = 1'b1;
                    wReg_o     = 1'b0;
                    ram_addr_o = ram_addr_s;
                    ram_en_n_o = 1'b0;
                    ram_oe_n_o = 1'b0;
                end
                ST_WR: begin
                    stallreq_o    = 1'b1;
                    wReg_o        = 1'b0;
                    ram_addr_o    = ram_addr_s;
                    ram_data_o    = wData_i;
                    ram_data_oe_o = 1'b1;
                    ram_en_n_o    = 1'b0;
                    ram_we_n_o    = 1'b0;
                end
                ST_DONE: begin
                    ram_addr_o = ram_addr_s;
                    ram_en_n_o = 1'b0;
                    if (is_load_r) begin
                        wData_o    = rdata_r;
                        ram_oe_n_o = 1'b0;
                    end else begin
                        // WE already high again; data/address held for hold time.
                        ram_data_o    = wData_i;
                        ram_data_oe_o = 1'b1;
                    end
                end
                default: begin
                    stallreq_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    typedef struct packed {
        logic [15:0] wdata;
        logic        wreg;
        logic [3:0]  wra;
        logic        stall;
        logic [17:0] addr;
        logic [15:0] rdo;
        logic        doe;
        logic        en_n;
        logic        oe_n;
        logic        we_n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] memAddr_i;
    logic        rMem_i;
    logic        wMem_i;
    logic [15:0] wData_i;
    logic        wReg_i;
    logic [3:0]  wRegAddr_i;
    logic [15:0] wData_o;
    logic        wReg_o;
    logic [3:0]  wRegAddr_o;
    logic        stallreq_o;
    logic [17:0] ram_addr_o;
    logic [15:0] ram_data_o;
    logic [15:0] ram_data_i;
    logic        ram_data_oe_o;
    logic        ram_en_n_o;
    logic        ram_oe_n_o;
    logic        ram_we_n_o;

    int tests_run = 0;
    int tests_failed = 0;

    exp_t  exp_q[$];
    string name_q[$];

    logic [15:0] sram [0:1023];

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .memAddr_i    (memAddr_i),
        .rMem_i       (rMem_i),
        .wMem_i       (wMem_i),
        .wData_i      (wData_i),
        .wReg_i       (wReg_i),
        .wRegAddr_i   (wRegAddr_i),
        .wData_o      (wData_o),
        .wReg_o       (wReg_o),
        .wRegAddr_o   (wRegAddr_o),
        .stallreq_o   (stallreq_o),
        .ram_addr_o   (ram_addr_o),
        .ram_data_o   (ram_data_o),
        .ram_data_i   (ram_data_i),
        .ram_data_oe_o(ram_data_oe_o),
        .ram_en_n_o   (ram_en_n_o),
        .ram_oe_n_o   (ram_oe_n_o),
        .ram_we_n_o   (ram_we_n_o)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM model: combinational read, write on the edge closing a WE-low cycle.
    assign ram_data_i = (!ram_en_n_o && !ram_oe_n_o) ? sram[ram_addr_o[9:0]] : 16'h0000;
    always @(posedge clk) begin
        if (!rst && !ram_en_n_o && !ram_we_n_o) sram[ram_addr_o[9:0]] <= ram_data_o;
    end

    function automatic exp_t mk(input logic [15:0] wd, input logic wr, input logic [3:0] wa,
                                input logic st, input logic [17:0] ad, input logic [15:0] rd,
                                input logic doe, input logic en, input logic oe, input logic we);
        exp_t e;
        e.wdata = wd; e.wreg = wr; e.wra = wa; e.stall = st; e.addr = ad;
        e.rdo = rd; e.doe = doe; e.en_n = en; e.oe_n = oe; e.we_n = we;
        return e;
    endfunction

    function automatic exp_t reset_vals();
        return mk(16'h0000, 1'b0, 4'h0, 1'b0, 18'h00000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);
    endfunction

    task automatic compare(input string name, input exp_t e);
        exp_t a;
        a = {wData_o, wReg_o, wRegAddr_o, stallreq_o, ram_addr_o, ram_data_o,
             ram_data_oe_o, ram_en_n_o, ram_oe_n_o, ram_we_n_o};
        tests_run++;
        if (a !== e) begin
            tests_failed++;
            $display("FAIL %s: got wd=%h wr=%b wa=%h st=%b ad=%h rd=%h doe=%b en=%b oe=%b we=%b | exp wd=%h wr=%b wa=%h st=%b ad=%h rd=%h doe=%b en=%b oe=%b we=%b",
                     name, a.wdata, a.wreg, a.wra, a.stall, a.addr, a.rdo, a.doe, a.en_n, a.oe_n, a.we_n,
                     e.wdata, e.wreg, e.wra, e.stall, e.addr, e.rdo, e.doe, e.en_n, e.oe_n, e.we_n);
        end
    endtask

    // Monitor: pops one expected vector per cycle; also guards against OE/WE both low.
    always @(negedge clk) begin
        if (exp_q.size() > 0) compare(name_q.pop_front(), exp_q.pop_front());
        if (!rst) begin
            tests_run++;
            if (!ram_oe_n_o && !ram_we_n_o) begin
                tests_failed++;
                $display("FAIL bus_safety: oe_n=%b we_n=%b, required not both 0", ram_oe_n_o, ram_we_n_o);
            end
        end
    end

    // Called just after a rising edge: apply inputs, queue expectation, run one cycle.
    task automatic cyc(input logic [15:0] a, input logic rm, input logic wm, input logic [15:0] wd,
                       input logic wr, input logic [3:0] wa, input string name, input exp_t e);
        memAddr_i = a; rMem_i = rm; wMem_i = wm; wData_i = wd; wReg_i = wr; wRegAddr_i = wa;
        exp_q.push_back(e);
        name_q.push_back(name);
        @(posedge clk); #1;
    endtask

    task automatic do_load(input logic [15:0] a, input logic [3:0] wa, input logic [15:0] rdv, input string name);
        logic [17:0] ad;
        ad = {2'b00, a};
        cyc(a, 1'b1, 1'b0, 16'h0000, 1'b1, wa, {name, "_c1"}, mk(16'h0000, 1'b0, wa, 1'b1, ad, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1));
        cyc(a, 1'b1, 1'b0, 16'h0000, 1'b1, wa, {name, "_c2"}, mk(16'h0000, 1'b0, wa, 1'b1, ad, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1));
        cyc(a, 1'b1, 1'b0, 16'h0000, 1'b1, wa, {name, "_c3"}, mk(rdv,      1'b1, wa, 1'b0, ad, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1));
    endtask

    task automatic do_store(input logic [15:0] a, input logic [15:0] d, input string name);
        logic [17:0] ad;
        ad = {2'b00, a};
        cyc(a, 1'b0, 1'b1, d, 1'b0, 4'h0, {name, "_c1"}, mk(d, 1'b0, 4'h0, 1'b1, ad, d, 1'b1, 1'b0, 1'b1, 1'b1));
        cyc(a, 1'b0, 1'b1, d, 1'b0, 4'h0, {name, "_c2"}, mk(d, 1'b0, 4'h0, 1'b1, ad, d, 1'b1, 1'b0, 1'b1, 1'b0));
        cyc(a, 1'b0, 1'b1, d, 1'b0, 4'h0, {name, "_c3"}, mk(d, 1'b0, 4'h0, 1'b0, ad, d, 1'b1, 1'b0, 1'b1, 1'b1));
    endtask

    task automatic check_mem(input logic [9:0] a, input logic [15:0] v, input string name);
        tests_run++;
        if (sram[a] !== v) begin
            tests_failed++;
            $display("FAIL %s: sram[%h]=%h, required %h", name, a, sram[a], v);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) sram[i] = 16'h0000;
        sram[10'h0A0] = 16'hBEEF;
        rst = 1'b1;
        memAddr_i = 16'h0000; rMem_i = 1'b0; wMem_i = 1'b0;
        wData_i = 16'h0000; wReg_i = 1'b0; wRegAddr_i = 4'h0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Async reset mid-cycle with a load pending: outputs must snap to reset values.
        memAddr_i = 16'h0040; rMem_i = 1'b1; wReg_i = 1'b1; wRegAddr_i = 4'h9; wData_i = 16'h7777;
        #1;
        rst = 1'b1;
        #1;
        compare("reset_async", reset_vals());
        rMem_i = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // ALU pass-through patterns.
        cyc(16'h0000, 1'b0, 1'b0, 16'h1234, 1'b1, 4'h3, "pass_1234", mk(16'h1234, 1'b1, 4'h3, 1'b0, 18'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1));
        cyc(16'h0055, 1'b0, 1'b0, 16'hFFFF, 1'b1, 4'hF, "pass_ffff", mk(16'hFFFF, 1'b1, 4'hF, 1'b0, 18'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1));
        cyc(16'h0000, 1'b0, 1'b0, 16'h00A5, 1'b0, 4'h6, "pass_nowr", mk(16'h00A5, 1'b0, 4'h6, 1'b0, 18'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1));

        // Load of preloaded word, store, then back-to-back store/load of one address.
        do_load(16'h00A0, 4'h5, 16'hBEEF, "load_a0");
        do_store(16'h0100, 16'h5A5A, "store_100");
        check_mem(10'h100, 16'h5A5A, "sram_after_store");
        do_store(16'h0120, 16'hC3C3, "b2b_store");
        do_load(16'h0120, 4'h7, 16'hC3C3, "b2b_load");
        cyc(16'h0000, 1'b0, 1'b0, 16'h0BAD, 1'b1, 4'h2, "pass_after", mk(16'h0BAD, 1'b1, 4'h2, 1'b0, 18'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1));

        // Reset while in WR: WE must rise immediately and nothing gets written.
        cyc(16'h0200, 1'b0, 1'b1, 16'h1111, 1'b0, 4'h0, "wrrst_setup", mk(16'h1111, 1'b0, 4'h0, 1'b1, 18'h00200, 16'h1111, 1'b1, 1'b0, 1'b1, 1'b1));
        #6;
        compare("wrrst_in_wr", mk(16'h1111, 1'b0, 4'h0, 1'b1, 18'h00200, 16'h1111, 1'b1, 1'b0, 1'b1, 1'b0));
        rst = 1'b1;
        #1;
        compare("wrrst_reset", reset_vals());
        wMem_i = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_mem(10'h200, 16'h0000, "sram_no_write");

        // Both requests set: load only, WE stays high.
        sram[10'h300] = 16'h3C3C;
        begin
            exp_t e1, e3;
            e1 = mk(16'h9999, 1'b0, 4'h4, 1'b1, 18'h00300, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
            e3 = mk(16'h3C3C, 1'b1, 4'h4, 1'b0, 18'h00300, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
            cyc(16'h0300, 1'b1, 1'b1, 16'h9999, 1'b1, 4'h4, "both_c1", e1);
            cyc(16'h0300, 1'b1, 1'b1, 16'h9999, 1'b1, 4'h4, "both_c2", e1);
            cyc(16'h0300, 1'b1, 1'b1, 16'h9999, 1'b1, 4'h4, "both_c3", e3);
        end
        check_mem(10'h300, 16'h3C3C, "sram_both_untouched");

        rMem_i = 1'b0; wMem_i = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
